// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer and its step timer.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_RALLY,
        ST_PAUSE,
        ST_OVER
    } state_t;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int DIV_W   = 24;
    localparam int SCORE_W = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 4'd1;
    endfunction

    // Lead is compared at 5 bits so that other+2 cannot wrap near the cap.
    function automatic logic wins(input logic [SCORE_W-1:0] mine,
                                  input logic [SCORE_W-1:0] other,
                                  input logic [SCORE_W-1:0] win_score);
        return (mine == SCORE_MAX) ||
               ((mine >= win_score) && ({1'b0, mine} >= {1'b0, other} + 5'd2));
    endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Loadable-period ball-step divider with a clamped period decrement; a new
// period only becomes active at the next wrap of the count.
module pong_step_timer
    import pong_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_INIT = 24'd12_500_000,
    parameter logic [DIV_W-1:0] DIV_MIN  = 24'd3_000_000,
    parameter logic [DIV_W-1:0] DIV_DEC  = 24'd500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load,
    input  logic dec,
    output logic tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_q, cur_d;
    logic [DIV_W-1:0] pend_q, pend_d;

    // Kept as its own assign so the tick never shares a process with load.
    assign tick = run && (cnt_q == cur_q - 24'd1);

    always_comb begin
        cnt_d  = cnt_q;
        cur_d  = cur_q;
        pend_d = pend_q;
        if (load) begin
            cnt_d  = '0;
            cur_d  = DIV_INIT;
            pend_d = DIV_INIT;
        end else if (run) begin
            if (dec) begin
                pend_d = (pend_q >= DIV_MIN + DIV_DEC) ? pend_q - DIV_DEC : DIV_MIN;
            end
            if (tick) begin
                cnt_d = '0;
                cur_d = pend_d;
            end else begin
                cnt_d = cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            cur_q  <= DIV_INIT;
            pend_q <= DIV_INIT;
        end else begin
            cnt_q  <= cnt_d;
            cur_q  <= cur_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer above the rally engine: serve, step pacing, scoring, win, pause.
// Define PONG_SPEEDUP_EN to let returned hits shorten the ball-step period.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter logic [DIV_W-1:0]   STEP_DIV_INIT = 24'd12_500_000,
    parameter logic [DIV_W-1:0]   STEP_DIV_MIN  = 24'd3_000_000,
    parameter logic [DIV_W-1:0]   STEP_DIV_DEC  = 24'd500_000,
    parameter logic [SCORE_W-1:0] WIN_SCORE     = 4'd11,
    parameter logic [2:0]         SERVE_ROTATE  = 3'd2,
    parameter logic [3:0]         PAUSE_STEPS   = 4'd4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_p0,
    input  logic               btn_p1,
    input  logic               hit,
    input  logic               point_p0,
    input  logic               point_p1,
    output logic               step_en,
    output logic               rally_start,
    output logic               server,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               in_rally,
    output logic               game_over,
    output logic               winner
);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic               server_q, server_d;
    logic               winner_q, winner_d;
    logic               let_q, let_d;
    logic [3:0]         pause_cnt_q, pause_cnt_d;
    logic               rally_start_q, rally_start_d;
    logic               step_en_q, step_en_d;

    logic step_tick, timer_load, timer_dec, timer_run;
    logic serve_btn, win0, win1, deuce, rotate;
    logic [SCORE_W:0] total;

`ifdef PONG_SPEEDUP_EN
    assign timer_dec = hit && (state_q == ST_RALLY);
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign timer_dec  = 1'b0;
`endif

    assign timer_run = (state_q == ST_RALLY) || (state_q == ST_PAUSE);
    assign serve_btn = (server_q == P0) ? btn_p0 : btn_p1;

    assign total  = {1'b0, score0_q} + {1'b0, score1_q};
    assign deuce  = (score0_q >= WIN_SCORE - 4'd1) && (score1_q >= WIN_SCORE - 4'd1);
    assign rotate = deuce || ((total % {2'b00, SERVE_ROTATE}) == 5'd0);
    assign win0   = wins(score0_q, score1_q, WIN_SCORE);
    assign win1   = wins(score1_q, score0_q, WIN_SCORE);

    pong_step_timer #(
        .DIV_INIT (STEP_DIV_INIT),
        .DIV_MIN  (STEP_DIV_MIN),
        .DIV_DEC  (STEP_DIV_DEC)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .run   (timer_run),
        .load  (timer_load),
        .dec   (timer_dec),
        .tick  (step_tick)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            score0_q      <= '0;
            score1_q      <= '0;
            server_q      <= P0;
            winner_q      <= P0;
            let_q         <= 1'b0;
            pause_cnt_q   <= '0;
            rally_start_q <= 1'b0;
            step_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            server_q      <= server_d;
            winner_q      <= winner_d;
            let_q         <= let_d;
            pause_cnt_q   <= pause_cnt_d;
            rally_start_q <= rally_start_d;
            step_en_q     <= step_en_d;
        end
    end

    // NOTE: every signal is given a default before the case, so no path
    // through this process can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        score0_d      = score0_q;
        score1_d      = score1_q;
        server_d      = server_q;
        winner_d      = winner_q;
        let_d         = let_q;
        pause_cnt_d   = pause_cnt_q;
        rally_start_d = 1'b0;
        timer_load    = 1'b0;
        step_en_d     = step_tick && (state_q == ST_RALLY);

        if (start) begin
            state_d  = ST_SERVE;
            score0_d = '0;
            score1_d = '0;
            server_d = P0;
            winner_d = P0;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    if (serve_btn) begin
                        rally_start_d = 1'b1;
                        timer_load    = 1'b1;
                        state_d       = ST_RALLY;
                    end
                end
                ST_RALLY: begin
                    if (point_p0 || point_p1) begin
                        timer_load  = 1'b1;
                        pause_cnt_d = '0;
                        let_d       = point_p0 && point_p1;
                        state_d     = ST_PAUSE;
                        if (point_p0 && !point_p1) score0_d = sat_inc(score0_q);
                        if (point_p1 && !point_p0) score1_d = sat_inc(score1_q);
                    end
                end
                ST_PAUSE: begin
                    if (step_tick) begin
                        if (pause_cnt_q == PAUSE_STEPS - 4'd1) begin
                            if (!let_q && rotate) server_d = ~server_q;
                            if (win0 || win1) begin
                                winner_d = win1 ? P1 : P0;
                                state_d  = ST_OVER;
                            end else begin
                                state_d = ST_SERVE;
                            end
                        end else begin
                            pause_cnt_d = pause_cnt_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        step_en     = step_en_q;
        rally_start = rally_start_q;
        server      = server_q;
        score0      = score0_q;
        score1      = score1_q;
        in_rally    = (state_q == ST_RALLY);
        game_over   = (state_q == ST_OVER);
        winner      = game_over && winner_q;
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a short step period and 2-step pause.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, btn_p0 = 1'b0, btn_p1 = 1'b0, hit = 1'b0;
    logic       point_p0 = 1'b0, point_p1 = 1'b0;
    logic       step_en, rally_start, server, in_rally, game_over, winner;
    logic [3:0] score0, score1;

    int n_pass = 0;
    int n_total = 0;

    pong_match_ctrl #(
        .STEP_DIV_INIT (24'd8),
        .STEP_DIV_MIN  (24'd4),
        .STEP_DIV_DEC  (24'd2),
        .WIN_SCORE     (4'd11),
        .SERVE_ROTATE  (3'd2),
        .PAUSE_STEPS   (4'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn_p0      (btn_p0),
        .btn_p1      (btn_p1),
        .hit         (hit),
        .point_p0    (point_p0),
        .point_p1    (point_p1),
        .step_en     (step_en),
        .rally_start (rally_start),
        .server      (server),
        .score0      (score0),
        .score1      (score1),
        .in_rally    (in_rally),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Cycles from the current negedge until step_en is seen, capped at 64.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_en !== 1'b1 && n < 64);
    endtask

    task automatic play_point(input logic p0, input logic p1);
        btn_p0 = 1'b1; btn_p1 = 1'b1;
        @(negedge clk);
        btn_p0 = 1'b0; btn_p1 = 1'b0;
        repeat (3) @(negedge clk);
        point_p0 = p0; point_p1 = p1;
        @(negedge clk);
        point_p0 = 1'b0; point_p1 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        int exp_sp1, exp_sp2, exp_sp3;
        logic seen;
`ifdef PONG_SPEEDUP_EN
        exp_sp1 = 6; exp_sp2 = 4; exp_sp3 = 4;
`else
        exp_sp1 = 8; exp_sp2 = 8; exp_sp3 = 8;
`endif
        #1;
        check("reset_outputs", {step_en, rally_start, server, score0, score1, in_rally, game_over, winner}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        start = 1'b1; @(negedge clk); start = 1'b0;
        btn_p1 = 1'b1; @(negedge clk); btn_p1 = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen |= rally_start | in_rally;
            @(negedge clk);
        end
        check("wrong_btn_ignored", seen, 0);

        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        check("rally_start", rally_start, 1);
        check("in_rally", in_rally, 1);
        wait_step(n);
        check("first_step_gap", n, 8);

        hit = 1'b1; @(negedge clk); hit = 1'b0;
        wait_step(n);
        wait_step(n);
        check("step_gap_hit1", n, exp_sp1);
        hit = 1'b1; @(negedge clk); hit = 1'b0;
        wait_step(n);
        wait_step(n);
        check("step_gap_hit2", n, exp_sp2);
        hit = 1'b1; @(negedge clk); hit = 1'b0;
        wait_step(n);
        wait_step(n);
        check("step_gap_hit3", n, exp_sp3);

        point_p1 = 1'b1; @(negedge clk); point_p1 = 1'b0;
        check("score1_after_point", score1, 1);
        check("left_rally", in_rally, 0);
        seen = 1'b0;
        repeat (20) begin
            seen |= step_en;
            @(negedge clk);
        end
        check("no_step_in_pause", seen, 0);
        check("server_after_1pt", server, 0);

        play_point(1'b1, 1'b0);
        check("score0_1_1", score0, 1);
        check("server_after_2pts", server, 1);

        for (int i = 0; i < 9; i++) play_point(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) play_point(1'b0, 1'b1);
        check("score_10_9", {score0, score1}, {4'd10, 4'd9});
        check("server_10_9", server, 1);
        play_point(1'b0, 1'b1);
        check("server_deuce_10_10", server, 0);
        play_point(1'b1, 1'b0);
        check("server_deuce_11_10", server, 1);
        check("no_win_11_10", game_over, 0);
        play_point(1'b1, 1'b0);
        check("score_12_10", {score0, score1}, {4'd12, 4'd10});
        check("game_over", game_over, 1);
        check("winner", winner, 0);

        start = 1'b1; @(negedge clk); start = 1'b0;
        check("restart_clears", {game_over, server, score0, score1}, 0);
        play_point(1'b1, 1'b0);
        play_point(1'b0, 1'b1);
        check("server_1_1", server, 1);
        play_point(1'b1, 1'b1);
        check("let_scores", {score0, score1}, {4'd1, 4'd1});
        check("let_server", server, 1);
        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        check("p0_btn_ignored", rally_start | in_rally, 0);
        btn_p1 = 1'b1; @(negedge clk); btn_p1 = 1'b0;
        check("p1_serves", rally_start, 1);
        repeat (2) @(negedge clk);
        point_p0 = 1'b1; @(negedge clk); point_p0 = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) play_point(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) play_point(1'b0, 1'b1);
        check("score_5_3", {score0, score1}, {4'd5, 4'd3});

        btn_p0 = 1'b1; btn_p1 = 1'b1; @(negedge clk); btn_p0 = 1'b0; btn_p1 = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("abort_clears", {server, score0, score1, in_rally}, 0);
        seen = 1'b0;
        repeat (5) begin
            seen |= rally_start;
            @(negedge clk);
        end
        check("abort_no_rally_start", seen, 0);
        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        check("abort_to_serve", rally_start, 1);

        repeat (2) @(negedge clk);
        point_p1 = 1'b1; @(negedge clk); point_p1 = 1'b0;
        repeat (20) @(negedge clk);
        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        wait_step(n);
        check("step_before_reset", step_en, 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_outputs", {step_en, rally_start, server, score0, score1, in_rally, game_over, winner}, 0);
        @(negedge clk);
        reset = 1'b0;
        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        check("idle_ignores_btn", rally_start | in_rally, 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        btn_p0 = 1'b1; @(negedge clk); btn_p0 = 1'b0;
        check("serve_after_reset", rally_start, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
